// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined signed add/sub, carry chain split into STAGES registered segments
// Optional ADDSUB_SATURATE_EN clamps sum on signed overflow at the final stage.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  // Per stage: skewed operands, deskewed partial sum, segment carry, valid
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  ain, bin, sin;
  logic              cinx;
  logic [SEG:0]      seg_res;
  logic              adv;

  // The whole pipeline advances in lockstep; only a stalled output holds it
  assign adv      = !(v_q[STAGES-1] && !out_ready);
  assign in_ready = adv;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    ain     = '0;
    bin     = '0;
    sin     = '0;
    cinx    = 1'b0;
    seg_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        ain    = a;
        bin    = b ^ {WIDTH{sub}};
        sin    = '0;
        cinx   = cin ^ sub;
        v_d[0] = in_valid;
      end else begin
        ain    = a_q[k-1];
        bin    = b_q[k-1];
        sin    = s_q[k-1];
        cinx   = c_q[k-1];
        v_d[k] = v_q[k-1];
      end
      seg_res = {1'b0, ain[k*SEG +: SEG]} + {1'b0, bin[k*SEG +: SEG]} + {{SEG{1'b0}}, cinx};
      sin[k*SEG +: SEG] = seg_res[SEG-1:0];
      a_d[k] = ain;
      b_d[k] = bin;
      c_d[k] = seg_res[SEG];
      s_d[k] = sin;
    end
    // Loop leaves the last stage's operands and result in ain/bin/sin
    ovf_d = (ain[WIDTH-1] == bin[WIDTH-1]) && (sin[WIDTH-1] != ain[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    if (ovf_d) begin
      s_d[STAGES-1] = ain[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub against an arithmetic model
module tb_pipelined_addsub;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        sub, cin, cout, overflow;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic c);
    exp_t   r;
    longint ex;
    longint ux, uy;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    if (!s) begin
      ex     = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      r.cout = (ux + uy + longint'(c)) >= 64'sh1_0000_0000;
    end else begin
      ex     = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
      r.cout = ux >= (uy + longint'(c));
    end
    r.ovf = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    r.sum = ex[31:0];
`ifdef ADDSUB_SATURATE_EN
    if (r.ovf) r.sum = (ex > 0) ? 32'h7fff_ffff : 32'h8000_0000;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // One clock: drive, score the beat leaving/entering before the edge, then step
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic is, input logic ic, input logic ordy);
    exp_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = is;
    cin       = ic;
    out_ready = ordy;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", {63'b0, out_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        check("sum", {32'b0, sum}, {32'b0, e.sum});
        check("cout", {63'b0, cout}, {63'b0, e.cout});
        check("overflow", {63'b0, overflow}, {63'b0, e.ovf});
      end
    end
    if (!rst && in_valid && in_ready) q.push_back(model(ia, ib, is, ic));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'($urandom), 32'($urandom), 1'($urandom), 1'($urandom), ordy);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [6];
    corner = '{32'h7fff_ffff, 32'h8000_0000, 32'h0000_0000, 32'hffff_ffff, 32'h0000_ffff, 32'h00ff_ffff};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return 32'($urandom);
  endfunction

  initial begin
    int          lat;
    logic [31:0] hold_sum;
    logic        hold_cout, hold_ovf;

    rst = 1'b1;
    idle(1'b1);
    idle(1'b1);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_sum", {32'b0, sum}, 64'd0);
    check("rst_cout", {63'b0, cout}, 64'd0);
    check("rst_overflow", {63'b0, overflow}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Max positive + 1, with latency measured from the accepting edge
    cycle(1'b1, 32'h7fff_ffff, 32'd1, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      idle(1'b1);
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    drain();

    cycle(1'b1, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1);
    drain();

    // Back-to-back adds: 50, 350, -300, 0
    cycle(1'b1, 32'd100, -32'sd50, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'd200, 32'd150, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, -32'sd100, -32'sd200, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, -32'sd50, 32'd50, 1'b0, 1'b0, 1'b1);
    drain();

    cycle(1'b1, 32'h0000_ffff, 32'd1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    drain();

    // Fill the pipe, then stall three cycles while offering new beats
    for (int i = 0; i < 4; i++) cycle(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
    check("bp_full_valid", {63'b0, out_valid}, 64'd1);
    hold_sum  = sum;
    hold_cout = cout;
    hold_ovf  = overflow;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b0);
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_sum_hold", {32'b0, sum}, {32'b0, hold_sum});
      check("bp_cout_hold", {63'b0, cout}, {63'b0, hold_cout});
      check("bp_ovf_hold", {63'b0, overflow}, {63'b0, hold_ovf});
    end
    drain();

    // Random traffic with random valid and back-pressure
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
    rst = 1'b1;
    idle(1'b1);
    q.delete();
    rst = 1'b0;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check("midrst_stays_idle", {63'b0, out_valid}, 64'd0);
    end
    cycle(1'b1, 32'd7, 32'd5, 1'b1, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      idle(1'b1);
      lat++;
    end
    check("post_rst_latency", 64'(lat), 64'd4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
